// File: rtl/exec_seq.sv
// exec_seq: multi-cycle RV32 execute sequencer.
// Reads operands, drives one execution unit, writes back, then returns a response.
module exec_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [4:0]  i_req_rd,
  input  logic [4:0]  i_req_rs1,
  input  logic [4:0]  i_req_rs2,
  input  logic [31:0] i_req_imm,
  input  logic        i_req_use_imm,
  input  logic [1:0]  i_req_unit,
  input  logic [3:0]  i_req_fn,
  input  logic        i_req_mod,
  output logic [4:0]  o_rf_rs1_addr,
  output logic [4:0]  o_rf_rs2_addr,
  output logic [4:0]  o_rf_rd_addr,
  output logic        o_rf_rd_wen,
  output logic [31:0] o_rf_rd_wdata,
  input  logic [31:0] i_rf_rs1_rdata,
  input  logic [31:0] i_rf_rs2_rdata,
  output logic [31:0] o_ex_op1,
  output logic [31:0] o_ex_op2,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_sub,
  input  logic [31:0] i_alu_result,
  output logic [1:0]  o_sh_dir,
  output logic        o_sh_arith,
  input  logic [31:0] i_sh_result,
  input  logic [5:0]  i_cmp_flags,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_taken,
  output logic        o_rsp_err
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RSP} state_t;
  state_t state, state_nxt;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, op1, op2, result;
  logic [1:0]  unit;
  logic [3:0]  fn;
  logic [7:0]  flags;
  logic        use_imm, mod, err, taken, illegal, flag, exec, live, wb, rsp;

  always_comb begin
    illegal = 1'b1;
    case (i_req_unit)
      2'd0: illegal = !$onehot(i_req_fn) || (i_req_mod && i_req_fn != 4'b0001);
      2'd1: illegal = !$onehot(i_req_fn[1:0]) || i_req_fn[3:2] != 2'b00 || (i_req_mod && i_req_fn[0]);
      2'd2: illegal = i_req_fn > 4'd5 || i_req_mod;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = i_req_valid ? READ : IDLE;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB:   state_nxt = RSP;
      RSP:  state_nxt = i_rsp_ready ? IDLE : RSP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;

  // Unused flag slots pad the select so fn[2:0] can index directly
  assign flags = {2'b00, i_cmp_flags};
  assign flag  = flags[fn[2:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {rd, rs1, rs2, imm, use_imm, unit, fn, mod, err} <= '0;
      {op1, op2, result, taken} <= '0;
    end else begin
      if (state == IDLE && i_req_valid) begin
        rd      <= i_req_rd;
        rs1     <= i_req_rs1;
        rs2     <= i_req_rs2;
        imm     <= i_req_imm;
        use_imm <= i_req_use_imm;
        unit    <= i_req_unit;
        fn      <= i_req_fn;
        mod     <= i_req_mod;
        err     <= illegal;
      end
      if (state == READ) begin
        op1 <= i_rf_rs1_rdata;
        op2 <= use_imm ? imm : i_rf_rs2_rdata;
      end
      if (state == EXEC) begin
        result <= err ? 32'd0 : unit == 2'd0 ? i_alu_result : unit == 2'd1 ? i_sh_result : {31'd0, flag};
        taken  <= !err && unit == 2'd2 && flag;
      end
    end
  end

  assign exec = state == EXEC;
  assign live = exec && !err;
  assign wb   = state == WB;
  assign rsp  = state == RSP;

  assign o_req_ready   = i_rst_n && state == IDLE;
  assign o_rf_rs1_addr = state == READ ? rs1 : 5'd0;
  assign o_rf_rs2_addr = state == READ ? rs2 : 5'd0;
  assign o_ex_op1      = exec ? op1 : 32'd0;
  assign o_ex_op2      = exec ? op2 : 32'd0;
  assign o_alu_op      = live && unit == 2'd0 ? fn : 4'd0;
  assign o_alu_sub     = live && unit == 2'd0 && mod;
  assign o_sh_dir      = live && unit == 2'd1 ? fn[1:0] : 2'd0;
  assign o_sh_arith    = live && unit == 2'd1 && mod;
  assign o_rf_rd_addr  = wb ? rd : 5'd0;
  assign o_rf_rd_wdata = wb ? result : 32'd0;
  assign o_rf_rd_wen   = wb && !err && rd != 5'd0;
  assign o_rsp_valid   = rsp;
  assign o_rsp_result  = rsp ? result : 32'd0;
  assign o_rsp_taken   = rsp && taken;
  assign o_rsp_err     = rsp && err;
endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: bench for exec_seq with register file, ALU, shifter and comparator models
// plus a response scoreboard.
module tb_exec_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, req_ready, req_use_imm, req_mod, rf_rd_wen, alu_sub, sh_arith;
  logic        rsp_valid, rsp_ready, rsp_taken, rsp_err;
  logic [4:0]  req_rd, req_rs1, req_rs2, rf_rs1_addr, rf_rs2_addr, rf_rd_addr;
  logic [31:0] req_imm, rf_rd_wdata, rf_rs1_rdata, rf_rs2_rdata, ex_op1, ex_op2;
  logic [31:0] alu_result, sh_result, rsp_result;
  logic signed [31:0] sra;
  logic [1:0]  req_unit, sh_dir;
  logic [3:0]  req_fn, alu_op;
  logic [5:0]  cmp_flags;
  logic [31:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'd0;

  typedef struct packed {logic [31:0] result; logic taken; logic err;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, wen_count = 0;

  always #5 clk = ~clk;

  exec_seq dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rd(req_rd), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2),
    .i_req_imm(req_imm), .i_req_use_imm(req_use_imm), .i_req_unit(req_unit),
    .i_req_fn(req_fn), .i_req_mod(req_mod),
    .o_rf_rs1_addr(rf_rs1_addr), .o_rf_rs2_addr(rf_rs2_addr), .o_rf_rd_addr(rf_rd_addr),
    .o_rf_rd_wen(rf_rd_wen), .o_rf_rd_wdata(rf_rd_wdata),
    .i_rf_rs1_rdata(rf_rs1_rdata), .i_rf_rs2_rdata(rf_rs2_rdata),
    .o_ex_op1(ex_op1), .o_ex_op2(ex_op2),
    .o_alu_op(alu_op), .o_alu_sub(alu_sub), .i_alu_result(alu_result),
    .o_sh_dir(sh_dir), .o_sh_arith(sh_arith), .i_sh_result(sh_result),
    .i_cmp_flags(cmp_flags),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_taken(rsp_taken), .o_rsp_err(rsp_err)
  );

  // Environment models: register file with x0 hardwired, and the three execution units
  assign rf_rs1_rdata = rf_rs1_addr == 5'd0 ? 32'd0 : rf[rf_rs1_addr];
  assign rf_rs2_rdata = rf_rs2_addr == 5'd0 ? 32'd0 : rf[rf_rs2_addr];
  always @(posedge clk)
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_rd_wen) rf[rf_rd_addr] <= rf_rd_wdata;

  assign sra = $signed(ex_op1) >>> ex_op2[4:0];
  always_comb begin
    alu_result = 32'd0;
    if (alu_op[0]) alu_result = alu_sub ? ex_op1 - ex_op2 : ex_op1 + ex_op2;
    if (alu_op[1]) alu_result = ex_op1 | ex_op2;
    if (alu_op[2]) alu_result = ex_op1 & ex_op2;
    if (alu_op[3]) alu_result = ex_op1 ^ ex_op2;
    sh_result = sh_dir[0] ? ex_op1 << ex_op2[4:0] : sh_dir[1] ? (sh_arith ? sra : ex_op1 >> ex_op2[4:0]) : 32'd0;
    cmp_flags = {ex_op1 >= ex_op2, $signed(ex_op1) >= $signed(ex_op2), ex_op1 < ex_op2,
                 $signed(ex_op1) < $signed(ex_op2), ex_op1 != ex_op2, ex_op1 == ex_op2};
  end

  always @(negedge clk) begin
    if (rf_rd_wen) wen_count++;
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got result=%h taken=%b err=%b with empty scoreboard", rsp_result, rsp_taken, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        if ({rsp_result, rsp_taken, rsp_err} !== mon_e) begin
          errors++;
          $display("FAIL rsp: got result=%h taken=%b err=%b, expected result=%h taken=%b err=%b",
                   rsp_result, rsp_taken, rsp_err, mon_e.result, mon_e.taken, mon_e.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic send(input logic [4:0] rd, rs1, rs2, input logic [31:0] imm, input logic use_imm,
                      input logic [1:0] unit, input logic [3:0] fn, input logic mod, input exp_t e);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_use_imm = use_imm;
    req_unit = unit; req_fn = fn; req_mod = mod; req_valid = 1'b1;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    req_rd = ~rd; req_rs1 = ~rs1; req_rs2 = ~rs2; req_imm = ~imm; req_use_imm = ~use_imm;
    req_unit = ~unit; req_fn = ~fn; req_mod = ~mod;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin step(); n++; end while (!req_ready && n < 30);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: ready=%b after %0d cycles, required 1", req_ready, n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, rsp_valid, rf_rd_wen, alu_op, sh_dir, rsp_result, ex_op1, rf_rs1_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b wen=%b alu_op=%b rsp_result=%h, required all 0",
               req_ready, rsp_valid, rf_rd_wen, alu_op, rsp_result);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_add();
    int w0;
    preload(1, 5); preload(2, 7); preload(3, 32'hdead);
    w0 = wen_count;
    send(3, 1, 2, 32'h0, 0, 0, 4'b0001, 0, exp_t'{32'd12, 1'b0, 1'b0});
    checks++;
    if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd2 || req_ready !== 1'b0) begin
      errors++; $display("FAIL add_read: rs1=%0d rs2=%0d ready=%b, required 1 2 0", rf_rs1_addr, rf_rs2_addr, req_ready);
    end
    step();
    checks++;
    if (alu_op !== 4'b0001 || alu_sub !== 1'b0 || ex_op1 !== 32'd5 || ex_op2 !== 32'd7 || sh_dir !== 2'b00) begin
      errors++; $display("FAIL add_exec: alu_op=%b sub=%b op1=%h op2=%h sh_dir=%b", alu_op, alu_sub, ex_op1, ex_op2, sh_dir);
    end
    step();
    checks++;
    if (rf_rd_wen !== 1'b1 || rf_rd_addr !== 5'd3 || rf_rd_wdata !== 32'd12) begin
      errors++; $display("FAIL add_wb: wen=%b addr=%0d wdata=%h, required 1 3 0000000c", rf_rd_wen, rf_rd_addr, rf_rd_wdata);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rf_rd_wen !== 1'b0) begin
      errors++; $display("FAIL add_rsp_timing: rsp_valid=%b wen=%b, required 1 0", rsp_valid, rf_rd_wen);
    end
    wait_idle();
    checks++;
    if (rf[3] !== 32'd12 || wen_count - w0 != 1) begin
      errors++; $display("FAIL add_write: x3=%h writes=%0d, required 0000000c 1", rf[3], wen_count - w0);
    end
  endtask

  task automatic test_sub_imm_stall();
    int w0;
    preload(1, 3);
    w0 = wen_count;
    rsp_ready = 1'b0;
    send(5, 1, 9, 32'd5, 1, 0, 4'b0001, 1, exp_t'{32'hfffffffe, 1'b0, 1'b0});
    step();
    checks++;
    if (alu_sub !== 1'b1 || ex_op2 !== 32'd5) begin
      errors++; $display("FAIL sub_exec: sub=%b op2=%h, required 1 00000005", alu_sub, ex_op2);
    end
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hfffffffe || rf_rd_wen !== 1'b0) begin
        errors++; $display("FAIL sub_stall%0d: valid=%b result=%h wen=%b", i, rsp_valid, rsp_result, rf_rd_wen);
      end
      step();
    end
    rsp_ready = 1'b1;
    wait_idle();
    checks++;
    if (rf[5] !== 32'hfffffffe || wen_count - w0 != 1) begin
      errors++; $display("FAIL sub_write: x5=%h writes=%0d, required fffffffe 1", rf[5], wen_count - w0);
    end
  endtask

  task automatic test_shift();
    preload(4, 32'h80000000);
    send(6, 4, 0, 32'd4, 1, 1, 4'b0010, 1, exp_t'{32'hf8000000, 1'b0, 1'b0});
    step();
    checks++;
    if (sh_dir !== 2'b10 || sh_arith !== 1'b1 || alu_op !== 4'b0000) begin
      errors++; $display("FAIL sra_exec: sh_dir=%b arith=%b alu_op=%b, required 10 1 0000", sh_dir, sh_arith, alu_op);
    end
    wait_idle();
    preload(7, 32'd1);
    send(8, 7, 0, 32'd31, 1, 1, 4'b0001, 0, exp_t'{32'h80000000, 1'b0, 1'b0});
    wait_idle();
    checks++;
    if (rf[6] !== 32'hf8000000 || rf[8] !== 32'h80000000) begin
      errors++; $display("FAIL shift_write: x6=%h x8=%h, required f8000000 80000000", rf[6], rf[8]);
    end
  endtask

  task automatic test_compare();
    int w0;
    preload(1, 32'hffffffff); preload(2, 32'd1); preload(9, 32'h55);
    w0 = wen_count;
    send(0, 1, 2, 32'h0, 0, 2, 4'd2, 0, exp_t'{32'd1, 1'b1, 1'b0});
    wait_idle();
    checks++;
    if (wen_count != w0) begin errors++; $display("FAIL cmp_rd0_wen: writes=%0d, required 0", wen_count - w0); end
    send(9, 1, 2, 32'h0, 0, 2, 4'd3, 0, exp_t'{32'd0, 1'b0, 1'b0});
    wait_idle();
    checks++;
    if (rf[9] !== 32'd0) begin errors++; $display("FAIL cmp_ltu_write: x9=%h, required 00000000", rf[9]); end
  endtask

  task automatic test_illegal();
    int w0;
    preload(10, 32'h77);
    w0 = wen_count;
    send(10, 1, 2, 32'h0, 0, 3, 4'b0001, 0, exp_t'{32'd0, 1'b0, 1'b1});
    step();
    checks++;
    if (alu_op !== 4'd0 || alu_sub !== 1'b0 || sh_dir !== 2'd0 || sh_arith !== 1'b0) begin
      errors++; $display("FAIL illegal_unit_ctl: alu_op=%b sub=%b sh_dir=%b arith=%b, required 0", alu_op, alu_sub, sh_dir, sh_arith);
    end
    step();
    checks++;
    if (rf_rd_wen !== 1'b0) begin errors++; $display("FAIL illegal_unit_wen: got %b, required 0", rf_rd_wen); end
    wait_idle();
    send(10, 1, 2, 32'h0, 0, 0, 4'b0011, 0, exp_t'{32'd0, 1'b0, 1'b1});
    step();
    checks++;
    if (alu_op !== 4'd0 || sh_dir !== 2'd0) begin
      errors++; $display("FAIL illegal_fn_ctl: alu_op=%b sh_dir=%b, required 0", alu_op, sh_dir);
    end
    wait_idle();
    checks++;
    if (wen_count != w0 || rf[10] !== 32'h77) begin
      errors++; $display("FAIL illegal_write: writes=%0d x10=%h, required 0 00000077", wen_count - w0, rf[10]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    preload(1, 5); preload(2, 7); preload(11, 32'haa);
    w0 = wen_count;
    send(11, 1, 2, 32'h0, 0, 0, 4'b0001, 0, exp_t'{32'd12, 1'b0, 1'b0});
    step();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({req_ready, rsp_valid, rf_rd_wen, alu_op, ex_op1, ex_op2} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: ready=%b rsp_valid=%b wen=%b alu_op=%b op1=%h, required all 0",
                         req_ready, rsp_valid, rf_rd_wen, alu_op, ex_op1);
    end
    step(); step();
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1 || rf[11] !== 32'haa || wen_count != w0) begin
      errors++; $display("FAIL mid_reset_after: ready=%b x11=%h writes=%0d, required 1 000000aa 0", req_ready, rf[11], wen_count - w0);
    end
  endtask

  task automatic test_back_to_back();
    send(11, 1, 2, 32'h0, 0, 0, 4'b0001, 0, exp_t'{32'd12, 1'b0, 1'b0});
    wait_idle();
    send(12, 1, 2, 32'h0, 0, 0, 4'b1000, 0, exp_t'{32'd2, 1'b0, 1'b0});
    wait_idle();
    checks++;
    if (rf[11] !== 32'd12 || rf[12] !== 32'd2 || sb.size() != 0) begin
      errors++; $display("FAIL back_to_back: x11=%h x12=%h pending=%0d, required 0000000c 00000002 0", rf[11], rf[12], sb.size());
    end
  endtask

  initial begin
    req_valid = 1'b0; rsp_ready = 1'b1;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    req_use_imm = 1'b0; req_unit = '0; req_fn = '0; req_mod = 1'b0;
    test_reset();
    test_add();
    test_sub_imm_stall();
    test_shift();
    test_compare();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
